// File: rtl/lhn_div12_seq.sv
// Sequential restoring divider by a constant: recovers operand and remainder from a
// multiply-by-DIVISOR product, one quotient bit per clock, with start/busy/done handshake.
module lhn_div12_seq #(
  parameter int unsigned DIVIDEND_W = 11,
  parameter int unsigned DIVISOR    = 12,
  parameter int unsigned REM_W      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [REM_W-1:0]      remainder,
  output logic                  exact
);

  localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [REM_W:0] DIV_P = (REM_W+1)'(DIVISOR);

  // Refuse to elaborate with an unusable divisor or a remainder field too narrow for it.
  if (DIVISOR == 0) begin : g_bad_divisor
    $error("lhn_div12_seq: DIVISOR must be nonzero");
  end
  if ((64'(1) << REM_W) <= 64'(DIVISOR) - 64'(1)) begin : g_bad_rem_w
    $error("lhn_div12_seq: REM_W too narrow for DIVISOR");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] shift_q, shift_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [REM_W-1:0]      remainder_q, remainder_d;
  logic                  exact_q, exact_d;

  logic [REM_W:0]        part;
  logic                  qbit;
  logic                  accept;

  assign accept = start && (state_q != S_RUN);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shift_d     = shift_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    exact_d     = exact_q;
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    part        = {rem_q, shift_q[DIVIDEND_W-1]};
    qbit        = (part >= DIV_P);

    if (accept) begin
      shift_d = dividend;
      rem_d   = '0;
      cnt_d   = CNT_W'(DIVIDEND_W - 1);
    end else if (state_q == S_RUN) begin
      rem_d   = qbit ? REM_W'(part - DIV_P) : REM_W'(part);
      shift_d = DIVIDEND_W'({shift_q, qbit});
      cnt_d   = cnt_q - CNT_W'(1);
      // Results are published only on the final step, never mid-iteration.
      if (cnt_q == '0) begin
        quotient_d  = shift_d;
        remainder_d = rem_d;
        exact_d     = (rem_d == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      exact_q     <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      exact_q     <= exact_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_lhn_div12_seq.sv
// Self-checking bench for lhn_div12_seq: directed cases, mid-run start, reset abort,
// back-to-back requests and random dividends against a plain div/mod reference.
module tb_lhn_div12_seq;

  localparam int unsigned W   = 11;
  localparam int unsigned DIV = 12;
  localparam int unsigned RW  = 4;
  localparam int          LAT = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  dividend;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [RW-1:0] remainder;
  logic          exact;

  int checks   = 0;
  int failures = 0;

  // Last results the DUT should be showing between done pulses
  int pub_q = 0;
  int pub_r = 0;
  int pub_e = 0;

  lhn_div12_seq #(.DIVIDEND_W(W), .DIVISOR(DIV), .REM_W(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .exact     (exact)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait for done, counting ticks and busy cycles; published outputs must hold meanwhile.
  task automatic wait_done(input string tag, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nbusy++;
      if (quotient !== W'(pub_q) || remainder !== RW'(pub_r) || exact !== 1'(pub_e))
        chk({tag, "_hold"}, int'(quotient), pub_q);
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
  endtask

  task automatic check_result(input string tag, input int d);
    pub_q = d / DIV;
    pub_r = d % DIV;
    pub_e = (pub_r == 0) ? 1 : 0;
    chk({tag, "_q"}, int'(quotient), pub_q);
    chk({tag, "_r"}, int'(remainder), pub_r);
    chk({tag, "_exact"}, int'(exact), pub_e);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  // Single request from IDLE; returns to IDLE afterwards.
  task automatic do_div(input string tag, input int d);
    int n, nb;
    start = 1'b1;
    dividend = W'(d);
    tick();
    start = 1'b0;
    dividend = W'($urandom);
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    wait_done(tag, n, nb);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_cycles"}, nb, LAT);
    check_result(tag, d);
    tick();
    chk({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int n, nb, d, extra_done;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_exact", int'(exact), 0);

    // Directed values
    do_div("d0", 0);
    do_div("d180", 180);
    do_div("d60", 60);
    do_div("d2047", 2047);
    do_div("d125", 125);

    // Start pulsed mid-run is ignored
    start = 1'b1;
    dividend = W'(120);
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    dividend = W'(2047);
    tick();
    start = 1'b0;
    wait_done("midstart", n, nb);
    chk("midstart_latency", n + 5, LAT);
    check_result("midstart", 120);
    extra_done = 0;
    repeat (15) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    chk("midstart_single_done", extra_done, 0);
    chk("midstart_idle_busy", int'(busy), 0);

    // Reset in the middle of a run discards everything
    start = 1'b1;
    dividend = W'(180);
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pub_q = 0;
    pub_r = 0;
    pub_e = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_exact", int'(exact), 0);
    extra_done = 0;
    repeat (15) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);
    do_div("after_abort", 60);

    // Start held high: back-to-back, done spaced DIVIDEND_W+1 cycles
    start = 1'b1;
    dividend = W'(12);
    tick();
    wait_done("b2b0", n, nb);
    chk("b2b0_latency", n, LAT);
    check_result("b2b0", 12);
    for (int i = 1; i < 5; i++) begin
      d = (i % 2 == 1) ? 13 : 12;
      dividend = W'(d);
      tick();
      chk("b2b_busy_reaccept", int'(busy), 1);
      wait_done("b2b", n, nb);
      chk("b2b_spacing", n + 1, LAT + 1);
      check_result("b2b", d);
    end
    start = 1'b0;
    tick();
    chk("b2b_end_idle", int'(busy), 0);

    // Random dividends
    for (int i = 0; i < 25; i++) begin
      do_div("rnd", int'($urandom_range(0, 2047)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
